// File: rtl/sram_arbiter2.sv
// Two-master round-robin arbiter onto a single valid/ready SRAM port,
// one outstanding transaction, with a watchdog that force-completes a stuck slave.
module sram_arbiter2 #(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            TIMEOUT  = 256,
  parameter logic [DW-1:0] ERR_DATA = DW'(32'hDEAD_BEEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_valid,
  input  logic            m0_instr,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_wstrb,
  output logic            m0_ready,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_valid,
  input  logic            m1_instr,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wstrb,
  output logic            m1_ready,
  output logic [DW-1:0]   m1_rdata,
  output logic            s_valid,
  output logic            s_instr,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_wstrb,
  input  logic            s_ready,
  input  logic [DW-1:0]   s_rdata,
  output logic            timeout_err,
  output logic [AW-1:0]   err_addr
);

  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : {WDW{1'b0}};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY0 = 2'd1;
  localparam logic [1:0] BUSY1 = 2'd2;

  logic [1:0]     state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
  logic [AW-1:0]  err_addr_q, err_addr_d;

  logic           busy_s;
  logic           sel_s;
  logic           wd_hit_s;
  logic           done_s;
  logic [AW-1:0]  addr_mux_s;
  logic [DW-1:0]  rdata_mux_s;

  // Slave-side request mux and completion/watchdog detection
  always_comb begin
    busy_s     = (state_q == BUSY0) || (state_q == BUSY1);
    sel_s      = (state_q == BUSY1);
    addr_mux_s = {AW{1'b0}};
    s_instr    = 1'b0;
    s_wdata    = {DW{1'b0}};
    s_wstrb    = {(DW/8){1'b0}};
    if (busy_s) begin
      addr_mux_s = sel_s ? m1_addr  : m0_addr;
      s_instr    = sel_s ? m1_instr : m0_instr;
      s_wdata    = sel_s ? m1_wdata : m0_wdata;
      s_wstrb    = sel_s ? m1_wstrb : m0_wstrb;
    end else begin
      addr_mux_s = {AW{1'b0}};
    end
    s_valid     = busy_s;
    s_addr      = addr_mux_s;
    // A real s_ready in the last watchdog cycle beats the timeout
    wd_hit_s    = busy_s && (TIMEOUT > 0) && (wd_cnt_q == WD_LAST) && !s_ready;
    done_s      = busy_s && (s_ready || wd_hit_s);
    rdata_mux_s = wd_hit_s ? ERR_DATA : s_rdata;
    timeout_err = wd_hit_s;
    err_addr    = err_addr_q;
  end

  // Master-side responses: only the granted master ever sees ready/rdata
  always_comb begin
    m0_ready = (state_q == BUSY0) && done_s;
    m1_ready = (state_q == BUSY1) && done_s;
    m0_rdata = m0_ready ? rdata_mux_s : {DW{1'b0}};
    m1_rdata = m1_ready ? rdata_mux_s : {DW{1'b0}};
  end

  // Next-state: arbitration in IDLE, completion and watchdog in BUSY
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wd_cnt_d     = wd_cnt_q;
    err_addr_d   = err_addr_q;
    case (state_q)
      IDLE: begin
        wd_cnt_d = {WDW{1'b0}};
        if (m0_valid && m1_valid) begin
          state_d = last_grant_q ? BUSY0 : BUSY1;
        end else if (m0_valid) begin
          state_d = BUSY0;
        end else if (m1_valid) begin
          state_d = BUSY1;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY0, BUSY1: begin
        if (done_s) begin
          state_d      = IDLE;
          last_grant_d = sel_s;
          wd_cnt_d     = {WDW{1'b0}};
          if (wd_hit_s) begin
            err_addr_d = addr_mux_s;
          end else begin
            err_addr_d = err_addr_q;
          end
        end else if (TIMEOUT > 0) begin
          wd_cnt_d = wd_cnt_q + WDW'(1);
        end else begin
          wd_cnt_d = {WDW{1'b0}};
        end
      end
      default: begin
        state_d  = IDLE;
        wd_cnt_d = {WDW{1'b0}};
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      wd_cnt_q     <= {WDW{1'b0}};
      err_addr_q   <= {AW{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wd_cnt_q     <= wd_cnt_d;
      err_addr_q   <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter2.sv
// Directed bench for sram_arbiter2 with hand-computed expectations (TIMEOUT=8).
module tb_sram_arbiter2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        timeout_err;
  logic [31:0] err_addr;

  int n_total = 0;
  int n_pass  = 0;

  sram_arbiter2 #(.AW(32), .DW(32), .TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .timeout_err(timeout_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // One IDLE cycle followed by a single-cycle BUSY completed by the slave
  task automatic serve(input int who, input logic [31:0] ea, input logic [3:0] es,
                       input logic [31:0] ew, input logic [31:0] rd);
    s_ready = 1'b0;
    @(negedge clk);
    check("gap_s_valid", {63'd0, s_valid}, 64'd0);
    cyc();
    s_ready = 1'b1;
    s_rdata = rd;
    @(negedge clk);
    check("busy_s_valid", {63'd0, s_valid}, 64'd1);
    check("busy_s_addr", {32'd0, s_addr}, {32'd0, ea});
    check("busy_s_wstrb", {60'd0, s_wstrb}, {60'd0, es});
    check("busy_s_wdata", {32'd0, s_wdata}, {32'd0, ew});
    if (who == 0) begin
      check("m0_ready", {63'd0, m0_ready}, 64'd1);
      check("m0_rdata", {32'd0, m0_rdata}, {32'd0, rd});
      check("m1_ready_idle", {63'd0, m1_ready}, 64'd0);
      check("m1_rdata_idle", {32'd0, m1_rdata}, 64'd0);
    end else begin
      check("m1_ready", {63'd0, m1_ready}, 64'd1);
      check("m1_rdata", {32'd0, m1_rdata}, {32'd0, rd});
      check("m0_ready_idle", {63'd0, m0_ready}, 64'd0);
      check("m0_rdata_idle", {32'd0, m0_rdata}, 64'd0);
    end
    cyc();
    s_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_wstrb = 4'd0;
    m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_wstrb = 4'd0;
    s_ready = 1'b0; s_rdata = 32'd0;
    cyc();
    cyc();
    @(negedge clk);
    check("rst_s_valid", {63'd0, s_valid}, 64'd0);
    check("rst_err_addr", {32'd0, err_addr}, 64'd0);
    check("rst_timeout_err", {63'd0, timeout_err}, 64'd0);
    cyc();
    rst = 1'b0;

    // Single m0 fetch, slave answers in the third BUSY cycle
    m0_valid = 1'b1; m0_instr = 1'b1; m0_addr = 32'h0000_0100;
    @(negedge clk);
    check("t1_same_cycle_s_valid", {63'd0, s_valid}, 64'd0);
    cyc();
    @(negedge clk);
    check("t1_s_valid", {63'd0, s_valid}, 64'd1);
    check("t1_s_addr", {32'd0, s_addr}, 64'h100);
    check("t1_s_instr", {63'd0, s_instr}, 64'd1);
    check("t1_m0_ready_wait", {63'd0, m0_ready}, 64'd0);
    cyc();
    @(negedge clk);
    check("t1_m0_ready_wait2", {63'd0, m0_ready}, 64'd0);
    cyc();
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    @(negedge clk);
    check("t1_m0_ready", {63'd0, m0_ready}, 64'd1);
    check("t1_m0_rdata", {32'd0, m0_rdata}, 64'h1234_5678);
    check("t1_m1_ready", {63'd0, m1_ready}, 64'd0);
    cyc();
    m0_valid = 1'b0; m0_instr = 1'b0; s_ready = 1'b0;
    @(negedge clk);
    check("t1_after_s_valid", {63'd0, s_valid}, 64'd0);
    check("t1_after_m0_rdata", {32'd0, m0_rdata}, 64'd0);

    // Simultaneous requests after reset: m0 first, then strict alternation
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h0000_0A00;
    m1_valid = 1'b1; m1_addr = 32'h0000_0B00;
    serve(0, 32'h0000_0A00, 4'd0, 32'd0, 32'h1111_0000);
    m0_valid = 1'b0;
    serve(1, 32'h0000_0B00, 4'd0, 32'd0, 32'h2222_0000);
    m1_valid = 1'b0;
    m0_valid = 1'b1; m1_valid = 1'b1;
    serve(0, 32'h0000_0A00, 4'd0, 32'd0, 32'h3333_0000);
    m0_valid = 1'b0;
    serve(1, 32'h0000_0B00, 4'd0, 32'd0, 32'h4444_0000);
    m1_valid = 1'b0;

    // m1 streams four writes while m0 keeps re-issuing a read
    m0_valid = 1'b1; m0_addr = 32'h0000_0300; m0_wstrb = 4'd0; m0_wdata = 32'd0;
    m1_valid = 1'b1; m1_wstrb = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      m1_addr  = 32'h0000_0400 + 32'(4 * i);
      m1_wdata = 32'hA5A5_0000 + 32'(i);
      serve(0, 32'h0000_0300, 4'd0, 32'd0, 32'h5555_0000 + 32'(i));
      serve(1, 32'h0000_0400 + 32'(4 * i), 4'b0011, 32'hA5A5_0000 + 32'(i), 32'd0);
    end
    m0_valid = 1'b0; m1_valid = 1'b0; m1_wstrb = 4'd0; m1_wdata = 32'd0;

    // Watchdog: slave never answers the m1 read
    m1_valid = 1'b1; m1_addr = 32'h2000_0040;
    cyc();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("t4_wait_m1_ready", {63'd0, m1_ready}, 64'd0);
      check("t4_wait_timeout_err", {63'd0, timeout_err}, 64'd0);
      cyc();
    end
    @(negedge clk);
    check("t4_m1_ready", {63'd0, m1_ready}, 64'd1);
    check("t4_m1_rdata", {32'd0, m1_rdata}, 64'hDEAD_BEEF);
    check("t4_timeout_err", {63'd0, timeout_err}, 64'd1);
    check("t4_m0_ready", {63'd0, m0_ready}, 64'd0);
    cyc();
    m1_valid = 1'b0;
    @(negedge clk);
    check("t4_pulse_end", {63'd0, timeout_err}, 64'd0);
    check("t4_s_valid_idle", {63'd0, s_valid}, 64'd0);
    check("t4_err_addr", {32'd0, err_addr}, 64'h2000_0040);

    // s_ready lands in the timeout cycle: normal completion wins
    m0_valid = 1'b1; m0_addr = 32'h0000_0500;
    cyc();
    for (int i = 0; i < 7; i++) cyc();
    s_ready = 1'b1; s_rdata = 32'hCAFE_0001;
    @(negedge clk);
    check("t5_m0_ready", {63'd0, m0_ready}, 64'd1);
    check("t5_m0_rdata", {32'd0, m0_rdata}, 64'hCAFE_0001);
    check("t5_timeout_err", {63'd0, timeout_err}, 64'd0);
    cyc();
    m0_valid = 1'b0; s_ready = 1'b0;
    @(negedge clk);
    check("t5_err_addr_held", {32'd0, err_addr}, 64'h2000_0040);

    // Reset one cycle into BUSY0 while m1 is waiting
    m0_valid = 1'b1; m0_addr = 32'h0000_0600;
    cyc();
    m1_valid = 1'b1; m1_addr = 32'h0000_0700;
    @(negedge clk);
    check("t6_busy_s_valid", {63'd0, s_valid}, 64'd1);
    #1;
    s_ready = 1'b1; s_rdata = 32'h7777_7777;
    rst = 1'b1;
    #1;
    check("t6_rst_s_valid", {63'd0, s_valid}, 64'd0);
    check("t6_rst_m0_ready", {63'd0, m0_ready}, 64'd0);
    check("t6_rst_err_addr", {32'd0, err_addr}, 64'd0);
    cyc();
    m0_valid = 1'b0; s_ready = 1'b0;
    cyc();
    rst = 1'b0;
    serve(1, 32'h0000_0700, 4'd0, 32'd0, 32'h8888_0000);
    m1_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
